// File: rtl/pix_group_edg_adapter_if.sv
// Bus bundle for the pixel-group edge adapter: packed word stream in, one
// pixel per cycle to and from the processor, and the repacked word out.
interface pix_group_edg_adapter_if #(
    parameter int CW  = 6,
    parameter int PPW = 2
);
    logic [PPW*3*CW-1:0] in_word;
    logic                in_valid;
    logic                in_ready;
    logic                bypass;
    logic [23:0]         pix_out;
    logic                pix_out_valid;
    logic [23:0]         pix_in;
    logic [PPW*3*CW-1:0] out_word;
    logic                out_valid;

    // Adapter side.
    modport slave (
        input  in_word, in_valid, bypass, pix_in,
        output in_ready, pix_out, pix_out_valid, out_word, out_valid
    );

    // Environment side: word source, processor and word sink.
    modport master (
        output in_word, in_valid, bypass, pix_in,
        input  in_ready, pix_out, pix_out_valid, out_word, out_valid
    );
endinterface

// File: rtl/pix_group_edg_adapter.sv
// Pixel-group adapter around a fixed-latency pixel processor.
// Accepts words of PPW packed pixels (CW bits per channel), expands each
// pixel to 24-bit RGB and launches one per cycle; processed (or bypassed)
// pixels are truncated back to CW bits and repacked into out_word.
module pix_group_edg_adapter #(
    parameter int CW       = 6,
    parameter int PPW      = 2,
    parameter int PROC_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    pix_group_edg_adapter_if.slave   bus
);
    localparam int PW = 3 * CW;
    localparam int WW = PPW * PW;
    localparam int IW = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [IW-1:0] LAST = IW'(PPW - 1);

    typedef enum logic {IDLE, SEND} state_t;

    // Channel expansion: left-justify each CW-bit channel in 8 bits.
    function automatic logic [23:0] expand(input logic [PW-1:0] p);
        logic [7:0] r, g, b;
        r = 8'(p[3*CW-1 -: CW]) << (8 - CW);
        g = 8'(p[2*CW-1 -: CW]) << (8 - CW);
        b = 8'(p[CW-1   -: CW]) << (8 - CW);
        return {r, g, b};
    endfunction

    // Channel truncation: keep the top CW bits of each 8-bit channel.
    function automatic logic [PW-1:0] truncate(input logic [23:0] p);
        return {p[23 -: CW], p[15 -: CW], p[7 -: CW]};
    endfunction

    function automatic logic [PW-1:0] pixel_of(input logic [WW-1:0] w,
                                               input logic [IW-1:0] k);
        return w[int'(k)*PW +: PW];
    endfunction

    // ---------------- serializer ----------------
    state_t          state;
    logic [IW-1:0]   idx;
    logic [WW-1:0]   word_q;
    logic            run_q;
    logic [23:0]     pix_out_q;
    logic            pix_out_valid_q;
    logic            in_ready;
    logic            accept;

    // run_q is low throughout reset and the reset cycle itself, so in_ready
    // stays 0 until the first edge after release.
    assign in_ready = run_q & ((state == IDLE) | ((state == SEND) & (idx == LAST)));
    assign accept   = bus.in_valid & in_ready;

    // Serializer FSM: capture a word, then present one expanded pixel per cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state           <= IDLE;
            idx             <= '0;
            word_q          <= '0;
            run_q           <= 1'b0;
            pix_out_q       <= '0;
            pix_out_valid_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                // New word: pixel 0 goes out straight away, no bubble after the last pixel.
                word_q          <= bus.in_word;
                idx             <= '0;
                state           <= SEND;
                pix_out_q       <= expand(bus.in_word[PW-1:0]);
                pix_out_valid_q <= 1'b1;
            end else if (state == SEND && idx != LAST) begin
                idx       <= idx + 1'b1;
                pix_out_q <= expand(pixel_of(word_q, idx + 1'b1));
            end else begin
                state           <= IDLE;
                pix_out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.pix_out       = pix_out_q;
    assign bus.pix_out_valid = pix_out_valid_q;

    // ---------------- return delay line ----------------
    logic        dl_valid  [PROC_LAT];
    logic        dl_bypass [PROC_LAT];
    logic [23:0] dl_pix    [PROC_LAT];

    // Delay line tracks each launched pixel and its bypass flag until pix_in returns.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is reset explicitly so no stale valid
        // bit from before reset can reach the collector.
        if (!reset) begin
            for (int i = 0; i < PROC_LAT; i++) begin
                dl_valid[i]  <= 1'b0;
                dl_bypass[i] <= 1'b0;
                dl_pix[i]    <= '0;
            end
        end else begin
            dl_valid[0]  <= pix_out_valid_q;
            dl_bypass[0] <= bus.bypass;
            dl_pix[0]    <= pix_out_q;
            for (int i = 1; i < PROC_LAT; i++) begin
                dl_valid[i]  <= dl_valid[i-1];
                dl_bypass[i] <= dl_bypass[i-1];
                dl_pix[i]    <= dl_pix[i-1];
            end
        end
    end

    // ---------------- collector ----------------
    logic [IW-1:0] col_idx;
    logic [WW-1:0] slot_q;
    logic [WW-1:0] slot_next;
    logic [PW-1:0] ret_pix;
    logic [WW-1:0] out_word_q;
    logic          out_valid_q;

    // Select the returning pixel and merge it into its slot.
    always_comb begin
        // NOTE: slot_next is given a full default before the partial update so
        // no latch is inferred.
        slot_next = slot_q;
        ret_pix   = truncate(dl_bypass[PROC_LAT-1] ? dl_pix[PROC_LAT-1] : bus.pix_in);
        slot_next[int'(col_idx)*PW +: PW] = ret_pix;
    end

    // Collector: store returning pixels, publish the word on the last slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_idx     <= '0;
            slot_q      <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (dl_valid[PROC_LAT-1]) begin
                slot_q <= slot_next;
                if (col_idx == LAST) begin
                    out_word_q  <= slot_next;
                    out_valid_q <= 1'b1;
                    col_idx     <= '0;
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end
        end
    end

    assign bus.out_word  = out_word_q;
    assign bus.out_valid = out_valid_q;
endmodule
